// File: rtl/qms_pwr_seq_pkg.sv
// qms_pkg: shared types and helpers for the QMS power-sequence generator.
//   state_t  : controller states IDLE / MUL / HOLD
//   sat_mul  : one saturating multiply step, acc * base, clamped to out_w bits
// QMS_CNT_W / QMS_OUT_W are the widest base / result the helper handles; the
// top-level defaults match them, narrower instances pass their own out_w.
package qms_pkg;

  localparam int QMS_CNT_W  = 8;
  localparam int QMS_OUT_W  = 16;
  localparam int QMS_PROD_W = QMS_CNT_W + QMS_OUT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [QMS_OUT_W-1:0] acc;
    logic                 ovf;
  } mul_res_t;

  // acc is always below 2^out_w, so any product bit at or above out_w means
  // the true value no longer fits. A sticky ovf keeps the result pinned.
  function automatic mul_res_t sat_mul(input logic [QMS_OUT_W-1:0] acc,
                                       input logic [QMS_CNT_W-1:0] base,
                                       input logic                 ovf,
                                       input int                   out_w);
    mul_res_t              res;
    logic [QMS_PROD_W-1:0] p;
    logic [QMS_OUT_W-1:0]  ones;
    p    = QMS_PROD_W'(acc) * QMS_PROD_W'(base);
    ones = {QMS_OUT_W{1'b1}} >> (QMS_OUT_W - out_w);
    if (ovf || ((p >> out_w) != '0)) begin
      res.acc = ones;
      res.ovf = 1'b1;
    end else begin
      res.acc = p[QMS_OUT_W-1:0];
      res.ovf = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/qms_pwr_seq_if.sv
// qms_pwr_seq_if: result channel of the power-sequence generator.
//   Dout   : result word, stable while Dvalid is high
//   Dvalid : result valid
//   Dready : consumer accepts
//   sat    : Dout was clamped
// master = producer (generator), slave = consumer.
interface qms_pwr_seq_if
  import qms_pkg::*;
#(
  parameter int OUT_W = QMS_OUT_W
);
  logic [OUT_W-1:0] Dout;
  logic             Dvalid;
  logic             Dready;
  logic             sat;

  modport master (output Dout, output Dvalid, output sat, input Dready);
  modport slave  (input Dout, input Dvalid, input sat, output Dready);
endinterface

// File: rtl/qms_pwr_seq_rst_sync.sv
// qms_rst_sync: reset synchronizer, asynchronous assert, synchronous deassert.
//   clk        : destination clock
//   arst_n     : raw asynchronous active-low reset
//   rst_n_sync : internal reset, low immediately with arst_n, high after
//                SYNC_STAGES rising edges of clk with arst_n high
module qms_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  output logic rst_n_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/qms_pwr_seq.sv
// qms_pwr_seq: wrapping base counter feeding a sequential saturating
// multiplier that produces cnt^exp, one multiply per cycle.
//   CLK, aRSTn : clock, asynchronous active-low reset (synchronized inside)
//   en         : start request, sampled only in IDLE
//   exp        : exponent, captured at start
//   limit      : last counter value before wrapping to 0
//   cnt        : current base counter value
//   bus        : result channel (Dout / Dvalid / Dready / sat)
module qms_pwr_seq
  import qms_pkg::*;
#(
  parameter int CNT_W       = QMS_CNT_W,
  parameter int EXP_W       = 3,
  parameter int OUT_W       = QMS_OUT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              aRSTn,
  input  logic              en,
  input  logic [EXP_W-1:0]  exp,
  input  logic [CNT_W-1:0]  limit,
  output logic [CNT_W-1:0]  cnt,
  qms_pwr_seq_if.master     bus
);

  logic rst_n;

  qms_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .clk        (CLK),
    .arst_n     (aRSTn),
    .rst_n_sync (rst_n)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic [EXP_W-1:0] rem_q, rem_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             sat_q, sat_d;
  mul_res_t         mul;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      sat_q    <= sat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    sat_d    = sat_q;
    mul      = sat_mul(QMS_OUT_W'(acc_q), QMS_CNT_W'(base_q), ovf_q, OUT_W);
    unique case (state_q)
      IDLE: begin
        if (en) begin
          base_d  = cnt_q;
          rem_d   = exp;
          acc_d   = OUT_W'(1);
          ovf_d   = 1'b0;
          state_d = MUL;
        end
      end
      MUL: begin
        // rem counts the multiplies still owed; reaching 0 publishes acc.
        if (rem_q != '0) begin
          acc_d = mul.acc[OUT_W-1:0];
          ovf_d = mul.ovf;
          rem_d = rem_q - 1'b1;
        end else begin
          dout_d   = acc_q;
          sat_d    = ovf_q;
          dvalid_d = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // >= so that lowering limit below cnt wraps at the next handshake.
        if (dvalid_q && bus.Dready) begin
          dvalid_d = 1'b0;
          cnt_d    = (cnt_q >= limit) ? '0 : cnt_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt        = cnt_q;
  assign bus.Dout   = dout_q;
  assign bus.Dvalid = dvalid_q;
  assign bus.sat    = sat_q;

endmodule

// File: tb/tb_qms_pwr_seq.sv
// tb_qms_pwr_seq: randomized bench for qms_pwr_seq with a reference model of
// the power sequence (integer power with clamp, counter wrap by rule).
module tb_qms_pwr_seq;

  localparam int CNT_W   = 8;
  localparam int EXP_W   = 3;
  localparam int OUT_W   = 16;
  localparam int SYNC    = 2;
  localparam longint MAXV = (64'd1 << OUT_W) - 1;

  logic             CLK = 1'b0;
  logic             aRSTn = 1'b0;
  logic             en = 1'b0;
  logic [EXP_W-1:0] exp_v = '0;
  logic [CNT_W-1:0] limit = '1;
  logic [CNT_W-1:0] cnt;

  qms_pwr_seq_if #(.OUT_W(OUT_W)) bus ();

  qms_pwr_seq #(
    .CNT_W(CNT_W), .EXP_W(EXP_W), .OUT_W(OUT_W), .SYNC_STAGES(SYNC)
  ) dut (
    .CLK   (CLK),
    .aRSTn (aRSTn),
    .en    (en),
    .exp   (exp_v),
    .limit (limit),
    .cnt   (cnt),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          mcnt   = 0;
  logic [63:0] last_dout;
  logic [63:0] last_sat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // True power, clamped to the result range; s marks that clamping happened.
  task automatic model_pow(input int b, input int e, output longint v, output bit s);
    v = 1;
    s = 1'b0;
    for (int i = 0; i < e; i++) begin
      v = v * b;
      if (v > MAXV) begin
        v = MAXV;
        s = 1'b1;
      end
    end
  endtask

  task automatic wait_valid(input string tag, input int exp_edges);
    int n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (!bus.Dvalid && n < 60);
    chk(tag, 64'(n), 64'(exp_edges));
  endtask

  task automatic handshake_and_check();
    @(posedge CLK);
    #1;
    chk("dvalid_drop", 64'(bus.Dvalid), 64'd0);
    mcnt = (mcnt >= int'(limit)) ? 0 : mcnt + 1;
    chk("cnt_after_hs", 64'(cnt), 64'(mcnt));
  endtask

  task automatic do_sample(input int e, input int bp);
    longint v;
    bit     s;
    @(negedge CLK);
    exp_v      = EXP_W'(e);
    en         = 1'b1;
    bus.Dready = (bp == 0);
    @(posedge CLK);
    #1;
    en = 1'b0;
    wait_valid("latency", e + 1);
    model_pow(mcnt, e, v, s);
    chk("dout", 64'(bus.Dout), 64'(v));
    chk("sat", 64'(bus.sat), 64'(s));
    chk("cnt_hold", 64'(cnt), 64'(mcnt));
    last_dout = 64'(bus.Dout);
    last_sat  = 64'(bus.sat);
    for (int i = 0; i < bp; i++) begin
      @(posedge CLK);
      #1;
      chk("bp_dvalid", 64'(bus.Dvalid), 64'd1);
      chk("bp_dout", 64'(bus.Dout), 64'(v));
      chk("bp_sat", 64'(bus.sat), 64'(s));
      chk("bp_cnt", 64'(cnt), 64'(mcnt));
    end
    if (bp > 0) begin
      @(negedge CLK);
      bus.Dready = 1'b1;
    end
    handshake_and_check();
  endtask

  // Release reset with en already high: the first start lands SYNC+1 edges later.
  task automatic release_and_first(input int e);
    longint v;
    bit     s;
    @(negedge CLK);
    aRSTn      = 1'b1;
    exp_v      = EXP_W'(e);
    en         = 1'b1;
    bus.Dready = 1'b1;
    mcnt       = 0;
    wait_valid("rst_release_latency", SYNC + 1 + e + 1);
    en = 1'b0;
    model_pow(0, e, v, s);
    chk("first_after_rst", 64'(bus.Dout), 64'(v));
    chk("first_after_rst_sat", 64'(bus.sat), 64'(s));
    handshake_and_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Dready = 1'b0;
    limit      = 8'd255;
    #23;
    chk("rst_dout", 64'(bus.Dout), 64'd0);
    chk("rst_dvalid", 64'(bus.Dvalid), 64'd0);
    chk("rst_sat", 64'(bus.sat), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    release_and_first(2);

    // Full square sweep over the counter range, then back to 0.
    for (int i = 1; i < 256; i++) begin
      do_sample(2, 0);
      chk("square", last_dout, 64'(i * i));
      chk("square_sat", last_sat, 64'd0);
    end
    do_sample(2, 0);
    chk("square_wrap", last_dout, 64'd0);

    // Random exponents, limits and backpressure.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) limit = CNT_W'($urandom_range(0, 255));
      do_sample(int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    // Saturation edge: 40^3 fits, 50^3 does not.
    limit = 8'd255;
    for (int g = 0; g < 300 && mcnt != 40; g++) do_sample(0, 0);
    do_sample(3, 0);
    chk("pow40", last_dout, 64'd64000);
    chk("pow40_sat", last_sat, 64'd0);
    for (int g = 0; g < 300 && mcnt != 50; g++) do_sample(0, 0);
    do_sample(3, 0);
    chk("pow50", last_dout, 64'hFFFF);
    chk("pow50_sat", last_sat, 64'd1);

    // Small wrap limit, then lowering limit below cnt.
    limit = 8'd3;
    do_sample(1, 0);
    for (int i = 0; i < 6; i++) begin
      do_sample(1, 0);
      chk("limit_seq", last_dout, 64'(i % 4));
    end
    do_sample(1, 0);
    limit = 8'd1;
    do_sample(1, 0);
    chk("limit_lower_dout", last_dout, 64'd3);
    chk("limit_lower_wrap", 64'(cnt), 64'd0);
    do_sample(0, 0);
    chk("zero_pow_zero", last_dout, 64'd1);

    // Backpressure in HOLD.
    limit = 8'd255;
    do_sample(2, 5);

    // Reset in the middle of a long computation.
    do_sample(7, 0);
    @(negedge CLK);
    exp_v      = 3'd7;
    en         = 1'b1;
    bus.Dready = 1'b1;
    @(posedge CLK);
    #1;
    en = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    aRSTn = 1'b0;
    #1;
    chk("midrst_dout", 64'(bus.Dout), 64'd0);
    chk("midrst_dvalid", 64'(bus.Dvalid), 64'd0);
    chk("midrst_sat", 64'(bus.sat), 64'd0);
    chk("midrst_cnt", 64'(cnt), 64'd0);
    release_and_first(3);
    do_sample(2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qms_pwr_seq.md
# qms_pwr_seq

Parametrised power-sequence generator. A wrapping base counter feeds a sequential multiplier that computes base^exp, one multiply per cycle, with saturation. Results leave through a registered valid/ready output. It succeeds the fixed 8-bit counter-squarer in the QMS lab: width, exponent and wrap limit are configurable, and the output supports backpressure.

## Interface
Parameters:
- CNT_W, 8: base counter width.
- EXP_W, 3: exponent input width; maximum exponent is 2^EXP_W-1.
- OUT_W, 16: result width.
- SYNC_STAGES, 2: depth of the internal reset synchronizer, ≥2.

Ports:
- CLK  in  1  single clock, rising edge.
- aRSTn  in  1  asynchronous active-low reset.
- en  in  1  start request; sampled only in IDLE.
- exp  in  EXP_W  exponent; captured at start.
- limit  in  CNT_W  last counter value before wrap to 0.
- cnt  out  CNT_W  current base counter value.
- Dout  out  OUT_W  result, held stable while Dvalid is high.
- Dvalid  out  1  result valid.
- Dready  in  1  consumer accepts.
- sat  out  1  the current Dout was saturated.

## Operation
- Reset synchronizer:
  - Internal reset asserts asynchronously when aRSTn is low.
  - It deasserts after SYNC_STAGES rising edges of CLK with aRSTn high.
- Reset values: cnt=0, Dout=0, Dvalid=0, sat=0. Internal state: state=IDLE, acc=0, rem=0.
- States: IDLE, MUL, HOLD.
- IDLE, en=1 at an edge:
  - base←cnt, rem←exp, acc←1, ovf←0.
  - Go to MUL.
- MUL, each edge:
  - If rem≠0: compute p = acc*base at OUT_W+CNT_W bits. If p's upper CNT_W bits are nonzero, or ovf is already set: acc←all-ones, ovf←1. Otherwise acc←p[OUT_W-1:0]. Then rem←rem-1.
  - If rem=0: Dout←acc, sat←ovf, Dvalid←1. Go to HOLD.
- HOLD:
  - Dout, sat and cnt are frozen.
  - On an edge with Dvalid&&Dready: Dvalid←0, and cnt←0 if cnt≥limit, else cnt+1. Go to IDLE.
- Boundary rules:
  - exp=0 gives Dout=1, including 0^0.
  - base=0 with exp≥1 gives Dout=0.
  - en dropping mid-computation has no effect; the computation completes.
  - exp and limit changes after capture affect only later samples. The limit rule uses ≥, so lowering limit below cnt wraps cnt to 0 at the next handshake.
  - Once ovf is set it stays set; acc stays all-ones.
- Reset mid-operation:
  - All outputs clear immediately to their reset values.
  - The first sample after release uses base 0.

## Timing
- Latency: with en high at edge E0 in IDLE and exp=e, Dvalid rises at edge E0+e+1.
- Sustained throughput with Dready=1 and en=1: one result per e+3 cycles (start edge, e multiplies, output edge, handshake edge).
- Dout, Dvalid, sat and cnt are all registered; there is no combinational path from inputs to outputs.
- Dready may be high before Dvalid rises; the handshake completes on the first edge where both are high.
- After aRSTn rises, the first en can be accepted at edge SYNC_STAGES+1.

## Structure
- Package qms_pkg holds:
  - state enum: IDLE, MUL, HOLD;
  - a saturating-multiply function parametrised through localparams derived from CNT_W and OUT_W.
- Sub-module qms_rst_sync (parameter SYNC_STAGES): async assert, synchronous deassert. It is reusable by other QMS blocks.
- Top contains the counter, the FSM/multiplier datapath and the output register. No vendor IP; the multiply is inferred.

## Test plan
- Defaults, exp=2, limit=255, en=1, Dready=1:
  - Dout sequence 0,1,4,9,…,65025, then 0 again.
  - sat stays 0 throughout.
  - Dvalid rises 3 edges after each start.
- exp=3 at cnt=50: Dout=16'hFFFF, sat=1. At cnt=40: Dout=64000, sat=0.
- exp=0: Dout=1 for every cnt, including 0.
- limit=3, exp=1: Dout sequence 0,1,2,3,0,1. Then set limit=1 while cnt=3: the next handshake wraps cnt to 0.
- Backpressure: hold Dready=0 for 5 cycles in HOLD.
  - Dout, sat and cnt stay stable and Dvalid stays 1.
  - Raise Dready: one handshake, then cnt increments.
- Pull aRSTn low during MUL:
  - Dout, Dvalid, sat and cnt clear without a clock edge.
  - After release, no start is accepted for 2 edges; the first result is 0^exp.
